// File: rtl/pipe_pkg.sv
// Shared constants for the pipeline-stage register slice: default widths,
// ctrl-bit and data-word indices, event-counter width and a saturating increment.
package pipe_pkg;

    localparam int unsigned CTRL_W_DEF = 8;
    localparam int unsigned REG_W_DEF  = 5;
    localparam int unsigned DATA_W_DEF = 32;
    localparam int unsigned CNT_W      = 16;

    // Control-bit positions within a ctrl beat
    localparam int unsigned C_MEMWR    = 0;
    localparam int unsigned C_BRANCH   = 1;
    localparam int unsigned C_MEMTOREG = 2;
    localparam int unsigned C_REGWR    = 3;
    localparam int unsigned C_JR       = 4;
    localparam int unsigned C_JAL      = 5;
    localparam int unsigned C_J        = 6;
    localparam int unsigned C_ZERO     = 7;

    // Data-word positions within the data bundle
    localparam int unsigned D_PCNEW  = 0;
    localparam int unsigned D_BUSA   = 1;
    localparam int unsigned D_BUSB   = 2;
    localparam int unsigned D_ALUOUT = 3;
    localparam int unsigned D_JPC    = 4;
    localparam int unsigned D_BPC    = 5;
    localparam int unsigned D_INST   = 6;

    // Increment that sticks at all-ones instead of wrapping
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
    endfunction

endpackage

// File: rtl/pipe_skid_buf.sv
// Two-entry skid FIFO used by pipe_stage_reg when PIPE_STAGE_SKID_EN is defined.
// The module only exists in that build. Falling-edge clocked; clr empties both
// entries.
`ifdef PIPE_STAGE_SKID_EN
module pipe_skid_buf #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] wdata,
    output logic [W-1:0] rdata,
    output logic         empty,
    output logic         full
);

    logic [W-1:0] r_mem [2];
    logic         r_wptr;
    logic         r_rptr;
    logic [1:0]   r_cnt;

    // Storage, pointers and occupancy; clear wipes entries as well as pointers
    always_ff @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mem[0] <= '0;
            r_mem[1] <= '0;
            r_wptr   <= 1'b0;
            r_rptr   <= 1'b0;
            r_cnt    <= '0;
        end else if (clr) begin
            r_mem[0] <= '0;
            r_mem[1] <= '0;
            r_wptr   <= 1'b0;
            r_rptr   <= 1'b0;
            r_cnt    <= '0;
        end else begin
            if (push) begin
                r_mem[r_wptr] <= wdata;
                r_wptr        <= ~r_wptr;
            end
            if (pop) begin
                r_rptr <= ~r_rptr;
            end
            case ({push, pop})
                2'b10:   r_cnt <= r_cnt + 2'd1;
                2'b01:   r_cnt <= r_cnt - 2'd1;
                default: r_cnt <= r_cnt;
            endcase
        end
    end

    assign rdata = r_mem[r_rptr];
    assign empty = (r_cnt == 2'd0);
    assign full  = r_cnt[1];

endmodule
`endif

// File: rtl/pipe_stage_reg.sv
// Falling-edge pipeline stage register with valid/ready handshake, flush
// squash and saturating flush/stall counters.
// Build option PIPE_STAGE_SKID_EN: adds a 2-entry skid buffer (registered
// in_ready); default build is a single register with combinational in_ready.
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int unsigned CTRL_W         = CTRL_W_DEF,
    parameter int unsigned REG_W          = REG_W_DEF,
    parameter int unsigned NREG           = 3,
    parameter int unsigned DATA_W         = DATA_W_DEF,
    parameter int unsigned NDATA          = 7,
    parameter int unsigned NFLUSH         = 2,
    parameter int unsigned FLUSH_ZERO_ALL = 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [CTRL_W-1:0]       in_ctrl,
    input  logic [NREG*REG_W-1:0]   in_reg,
    input  logic [NDATA*DATA_W-1:0] in_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [CTRL_W-1:0]       out_ctrl,
    output logic [NREG*REG_W-1:0]   out_reg,
    output logic [NDATA*DATA_W-1:0] out_data,
    input  logic [NFLUSH-1:0]       flush,
    output logic [15:0]             flush_cnt,
    output logic [15:0]             stall_cnt
);

    logic                    r_out_valid;
    logic [CTRL_W-1:0]       r_out_ctrl;
    logic [NREG*REG_W-1:0]   r_out_reg;
    logic [NDATA*DATA_W-1:0] r_out_data;
    logic [CNT_W-1:0]        r_flush_cnt;
    logic [CNT_W-1:0]        r_stall_cnt;

    logic                    w_flush;
    logic                    w_hold;
    logic                    w_cap_valid;
    logic [CTRL_W-1:0]       w_cap_ctrl;
    logic [NREG*REG_W-1:0]   w_cap_reg;
    logic [NDATA*DATA_W-1:0] w_cap_data;

    assign w_flush = |flush;
    assign w_hold  = r_out_valid & ~out_ready;

`ifdef PIPE_STAGE_SKID_EN
    localparam int unsigned PAY_W = CTRL_W + NREG*REG_W + NDATA*DATA_W;

    logic             w_sk_push;
    logic             w_sk_pop;
    logic             w_sk_empty;
    logic             w_sk_full;
    logic [PAY_W-1:0] w_sk_rdata;

    // Input bypasses straight to the output register when the skid is empty and
    // the register is free; otherwise it queues behind older beats.
    assign in_ready    = ~w_sk_full;
    assign w_sk_pop    = ~w_flush & ~w_hold & ~w_sk_empty;
    assign w_sk_push   = in_valid & ~w_sk_full & ~w_flush & ~(~w_hold & w_sk_empty);
    assign w_cap_valid = ~w_sk_empty | in_valid;
    assign w_cap_ctrl  = w_sk_empty ? in_ctrl : w_sk_rdata[PAY_W-1 -: CTRL_W];
    assign w_cap_reg   = w_sk_empty ? in_reg  : w_sk_rdata[NDATA*DATA_W +: NREG*REG_W];
    assign w_cap_data  = w_sk_empty ? in_data : w_sk_rdata[NDATA*DATA_W-1:0];

    pipe_skid_buf #(
        .W (PAY_W)
    ) u_skid (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (w_flush),
        .push  (w_sk_push),
        .pop   (w_sk_pop),
        .wdata ({in_ctrl, in_reg, in_data}),
        .rdata (w_sk_rdata),
        .empty (w_sk_empty),
        .full  (w_sk_full)
    );
`else
    assign in_ready    = out_ready | ~r_out_valid | w_flush;
    assign w_cap_valid = in_valid;
    assign w_cap_ctrl  = in_ctrl;
    assign w_cap_reg   = in_reg;
    assign w_cap_data  = in_data;
`endif

    // Output register: flush beats hold, hold beats capture, otherwise bubble
    always_ff @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_out_ctrl  <= '0;
            r_out_reg   <= '0;
            r_out_data  <= '0;
        end else if (w_flush) begin
            r_out_valid <= 1'b0;
            r_out_ctrl  <= '0;
            if (FLUSH_ZERO_ALL != 0) begin
                r_out_reg  <= '0;
                r_out_data <= '0;
            end
        end else if (w_hold) begin
            r_out_valid <= r_out_valid;
        end else if (w_cap_valid) begin
            r_out_valid <= 1'b1;
            r_out_ctrl  <= w_cap_ctrl;
            r_out_reg   <= w_cap_reg;
            r_out_data  <= w_cap_data;
        end else begin
            r_out_valid <= 1'b0;
            r_out_ctrl  <= '0;
        end
    end

    // Saturating event counters; a flushed edge never counts as a stall
    always_ff @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_flush_cnt <= '0;
            r_stall_cnt <= '0;
        end else begin
            if (w_flush) begin
                r_flush_cnt <= sat_inc(r_flush_cnt);
            end
            if (w_hold & ~w_flush) begin
                r_stall_cnt <= sat_inc(r_stall_cnt);
            end
        end
    end

    assign out_valid = r_out_valid;
    assign out_ctrl  = r_out_ctrl;
    assign out_reg   = r_out_reg;
    assign out_data  = r_out_data;
    assign flush_cnt = r_flush_cnt;
    assign stall_cnt = r_stall_cnt;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench for pipe_stage_reg: reset, streaming, stall, bubble, flush
// (both FLUSH_ZERO_ALL settings), in-order scoreboard and counter saturation.
module tb_pipe_stage_reg;
    import pipe_pkg::*;

    localparam int unsigned CW = 8;
    localparam int unsigned RW = 5;
    localparam int unsigned NR = 3;
    localparam int unsigned DW = 32;
    localparam int unsigned ND = 7;
    localparam int unsigned NF = 2;

    logic               clk = 1'b1;
    logic               rst_n;
    logic               in_valid;
    logic [CW-1:0]      in_ctrl;
    logic [NR*RW-1:0]   in_reg;
    logic [ND*DW-1:0]   in_data;
    logic               out_ready;
    logic [NF-1:0]      flush;

    logic               in_ready,  nz_in_ready;
    logic               out_valid, nz_out_valid;
    logic [CW-1:0]      out_ctrl,  nz_out_ctrl;
    logic [NR*RW-1:0]   out_reg,   nz_out_reg;
    logic [ND*DW-1:0]   out_data,  nz_out_data;
    logic [15:0]        flush_cnt, nz_flush_cnt;
    logic [15:0]        stall_cnt, nz_stall_cnt;

    int unsigned n_run  = 0;
    int unsigned n_fail = 0;

    always #5 clk = ~clk;

    pipe_stage_reg dut (
        .clk (clk), .rst_n (rst_n),
        .in_valid (in_valid), .in_ready (in_ready),
        .in_ctrl (in_ctrl), .in_reg (in_reg), .in_data (in_data),
        .out_valid (out_valid), .out_ready (out_ready),
        .out_ctrl (out_ctrl), .out_reg (out_reg), .out_data (out_data),
        .flush (flush), .flush_cnt (flush_cnt), .stall_cnt (stall_cnt)
    );

    pipe_stage_reg #(.FLUSH_ZERO_ALL(0)) dut_nz (
        .clk (clk), .rst_n (rst_n),
        .in_valid (in_valid), .in_ready (nz_in_ready),
        .in_ctrl (in_ctrl), .in_reg (in_reg), .in_data (in_data),
        .out_valid (nz_out_valid), .out_ready (out_ready),
        .out_ctrl (nz_out_ctrl), .out_reg (nz_out_reg), .out_data (nz_out_data),
        .flush (flush), .flush_cnt (nz_flush_cnt), .stall_cnt (nz_stall_cnt)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic set_beat(input logic [CW-1:0] c, input int unsigned idx, input logic [31:0] w);
        in_ctrl = c;
        in_reg  = '0;
        in_data = '0;
        in_data[idx*DW +: DW] = w;
    endtask

    logic [31:0] q[$];
    int unsigned sent, rcvd, cyc;
    logic [31:0] exp_w;

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; in_ctrl = '0; in_reg = '0; in_data = '0;
        out_ready = 1'b1; flush = '0;
        #2;
        chk("rst_valid", out_valid, 0);
        chk("rst_data_any", |out_data, 0);
        chk("rst_flush_cnt", flush_cnt, 0);
        chk("rst_stall_cnt", stall_cnt, 0);
        chk("rst_in_ready", in_ready, 1);
        tick();
        rst_n = 1'b1;
        #1;
        chk("rel_in_ready", in_ready, 1);

        // Streaming: one beat per edge, latency one edge
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'b1; out_ready = 1'b1;
            set_beat(8'h08, D_INST, 32'h1000 + i);
            tick();
            chk("stream_valid", out_valid, 1);
            chk("stream_inst", out_data[D_INST*DW +: DW], 32'h1000 + i);
        end

        // Stall: held beat, stall counter, backpressure
        set_beat(8'h09, D_ALUOUT, 32'hDEAD_BEEF);
        tick();
        in_valid = 1'b0; out_ready = 1'b0;
        #1;
`ifndef PIPE_STAGE_SKID_EN
        chk("stall_in_ready", in_ready, 0);
`endif
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("stall_valid", out_valid, 1);
            chk("stall_ctrl", out_ctrl, 8'h09);
            chk("stall_alu", out_data[D_ALUOUT*DW +: DW], 32'hDEAD_BEEF);
        end
        chk("stall_cnt4", stall_cnt, 4);

        // Bubble: valid and ctrl drop, data fields kept
        out_ready = 1'b1;
        tick();
        chk("bubble_valid", out_valid, 0);
        chk("bubble_ctrl", out_ctrl, 0);
        chk("bubble_alu_kept", out_data[D_ALUOUT*DW +: DW], 32'hDEAD_BEEF);

        // Flush beats a stalled beat and discards the same-edge input
        in_valid = 1'b1;
        set_beat(8'h08, D_ALUOUT, 32'hCAFE_F00D);
        tick();
        chk("preflush_valid", out_valid, 1);
        out_ready = 1'b0; flush = 2'b01;
        set_beat(8'hFF, D_ALUOUT, 32'h1234_5678);
        #1;
`ifndef PIPE_STAGE_SKID_EN
        chk("flush_in_ready", in_ready, 1);
`endif
        tick();
        chk("flush_valid", out_valid, 0);
        chk("flush_ctrl", out_ctrl, 0);
        chk("flush_data_any", |out_data, 0);
        chk("flush_cnt1", flush_cnt, 1);
        chk("flush_no_stall", stall_cnt, 4);
        chk("nz_flush_ctrl", nz_out_ctrl, 0);
        chk("nz_flush_alu_kept", nz_out_data[D_ALUOUT*DW +: DW], 32'hCAFE_F00D);
        flush = '0; in_valid = 1'b0; out_ready = 1'b1;
        tick();
        chk("flush_discarded", out_valid, 0);

        // Upper flush bit also squashes
        in_valid = 1'b1;
        set_beat(8'h01, D_INST, 32'h0000_0777);
        tick();
        flush = 2'b10; in_valid = 1'b0;
        tick();
        chk("flush1_valid", out_valid, 0);
        chk("flush_cnt2", flush_cnt, 2);
        flush = '0;

        // Random backpressure with an in-order scoreboard
        sent = 0; rcvd = 0; cyc = 0;
        while (rcvd < 1000 && cyc < 8000) begin
            out_ready = 1'($urandom_range(0, 1));
            in_valid  = (sent < 1000) && ($urandom_range(0, 3) != 0);
            set_beat(8'h08, D_INST, 32'hA000_0000 + sent);
            #1;
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    chk("sb_extra_beat", 1, 0);
                end else begin
                    exp_w = q.pop_front();
                    chk("sb_inst", out_data[D_INST*DW +: DW], exp_w);
                    rcvd++;
                end
            end
            if (in_valid && in_ready) begin
                q.push_back(32'hA000_0000 + sent);
                sent++;
            end
            tick();
            cyc++;
        end
        chk("sb_count", rcvd, 1000);
        chk("sb_within_bound", cyc < 8000, 1);

        // Asynchronous reset in the middle of a valid beat
        in_valid = 1'b1; out_ready = 1'b0;
        set_beat(8'h08, D_ALUOUT, 32'h55AA_55AA);
        tick();
        in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", out_valid, 0);
        chk("mid_rst_data_any", |out_data, 0);
        chk("mid_rst_flush_cnt", flush_cnt, 0);
        chk("mid_rst_in_ready", in_ready, 1);
        @(posedge clk);
        rst_n = 1'b1;
        #1;

        // Flush counter saturation
        flush = 2'b11; out_ready = 1'b0;
        repeat (65534) tick();
        chk("sat_fffe", flush_cnt, 16'hFFFE);
        tick();
        chk("sat_ffff", flush_cnt, 16'hFFFF);
        repeat (4465) tick();
        chk("sat_no_wrap", flush_cnt, 16'hFFFF);
        chk("sat_nz", nz_flush_cnt, 16'hFFFF);
        chk("sat_no_stall", stall_cnt, 0);
        flush = '0;

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule

// File: doc/pipe_stage_reg.md
PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

Interface
REQ-001 SHALL have parameter CTRL_W, default 8, control bits per beat (bit0 MemWr, 1 Branch, 2 MemtoReg, 3 RegWr, 4 jr, 5 jal, 6 J, 7 zero).
REQ-002 SHALL have parameter REG_W, default 5, register-specifier width.
REQ-003 SHALL have parameter NREG, default 3, register-specifier count (rw, rs, rt).
REQ-004 SHALL have parameter DATA_W, default 32, data-word width.
REQ-005 SHALL have parameter NDATA, default 7, data-word count (pcNew, busA, busB, ALUout, Jpc, Bpc, inst).
REQ-006 SHALL have parameter NFLUSH, default 2, flush-source count.
REQ-007 SHALL have parameter FLUSH_ZERO_ALL, default 1; 1 = flush zeroes all fields, 0 = flush zeroes ctrl only.
REQ-008 SHALL have port clk  in  1  single clock; all state updates on the falling edge.
REQ-009 SHALL have port rst_n  in  1  asynchronous active-low reset.
REQ-010 SHALL have ports in_valid in 1, in_ready out 1: upstream handshake.
REQ-011 SHALL have ports in_ctrl in CTRL_W, in_reg in NREG*REG_W, in_data in NDATA*DATA_W: upstream payload.
REQ-012 SHALL have ports out_valid out 1, out_ready in 1: downstream handshake.
REQ-013 SHALL have ports out_ctrl out CTRL_W, out_reg out NREG*REG_W, out_data out NDATA*DATA_W: registered payload.
REQ-014 SHALL have port flush in NFLUSH; any set bit squashes the stage (taken jump, load-use hazard).
REQ-015 SHALL have ports flush_cnt out 16 and stall_cnt out 16: saturating event counters.

Function
REQ-016 Beat SHALL transfer in on a falling edge where in_valid & in_ready; latency one edge to out_*.
REQ-017 Beat SHALL leave on a falling edge where out_valid & out_ready.
REQ-018 Without skid, in_ready SHALL be combinational: out_ready | ~out_valid | (|flush).
REQ-019 While out_valid & ~out_ready & no flush, all out_* SHALL hold stable.
REQ-020 Edge with no transfer-in, no hold and no flush SHALL produce a bubble: out_valid 0, out_ctrl 0, other fields unchanged.
REQ-021 Any flush bit at an edge SHALL take priority over capture and hold: out_valid 0, fields zeroed per FLUSH_ZERO_ALL, same-edge input beat accepted and discarded.
REQ-022 out_ctrl SHALL be all-zero whenever out_valid is 0.
REQ-023 flush_cnt SHALL +1 per edge with |flush, saturating at 16'hFFFF.
REQ-024 stall_cnt SHALL +1 per edge with out_valid & ~out_ready & ~|flush, saturating at 16'hFFFF.
REQ-025 Beat order SHALL be preserved; no beat duplicated or dropped except by flush.

Reset
REQ-026 rst_n low SHALL immediately clear out_valid, all payload, both counters and skid storage, independent of clk.
REQ-027 After reset release, in_ready SHALL be 1 and first capture SHALL occur at the first falling edge with in_valid.

Configuration
REQ-028 Macro PIPE_STAGE_SKID_EN defined SHALL add a 2-entry skid buffer: in_ready registered (= ~skid_full), full throughput with out_ready toggling, latency still one edge when empty, flush clears both entries.
REQ-029 Macro PIPE_STAGE_SKID_EN undefined SHALL give the single-register behaviour of REQ-018.

Structure
REQ-030 Shared package pipe_pkg SHALL hold CTRL_W, REG_W, DATA_W defaults, ctrl-bit index constants, data-word index constants, counter width.
REQ-031 Skid storage SHALL be sub-module pipe_skid_buf, instantiated only under PIPE_STAGE_SKID_EN.

Verification
REQ-032 Reset: rst_n low mid-beat -> out_valid 0, out_data 0, flush_cnt 0, in_ready 1 without clock edge.
REQ-033 Streaming: 10 beats inst=32'h1000+i, out_ready=1 -> out_data inst words in order, one per edge, latency 1.
REQ-034 Stall: out_ready=0 for 4 edges with valid beat ALUout=32'hDEAD_BEEF -> held value, stall_cnt=4, in_ready 0 (no skid).
REQ-035 Flush: flush=2'b01 with in_valid, ctrl=8'hFF -> out_valid 0, out_ctrl 0, input discarded, flush_cnt=1; FLUSH_ZERO_ALL=0 -> out_data unchanged.
REQ-036 Saturation: force 70000 flush edges -> flush_cnt 16'hFFFF, no wrap.
REQ-037 Skid (macro on): out_ready random 50%, 1000 beats -> scoreboard exact in-order match, none lost.
